// File: rtl/fluxo_dados.sv
// Datapath for a repeated-addition unsigned multiplier: RA holds the multiplicand,
// AR counts remaining additions, ACC accumulates, and P/PRONTO latch the result on SAIDA.
module fluxo_dados #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOAD,
  input  logic               SAIDA,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   AR,
  output logic [2*WIDTH-1:0] P,
  output logic               PRONTO
);

  logic [WIDTH-1:0]   r_ra;
  logic [WIDTH-1:0]   r_ar;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic               r_pronto;
  logic               w_iterate;

  // The multiplicand is zero-extended; the sum wraps modulo 2^(2*WIDTH),
  // which cannot happen for any product of two WIDTH-bit operands.
  function automatic logic [2*WIDTH-1:0] acc_add(input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]   ra);
    acc_add = acc + {{WIDTH{1'b0}}, ra};
  endfunction

  assign w_iterate = (r_ar != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ra     <= '0;
      r_ar     <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_pronto <= 1'b0;
    end else if (LOAD) begin
      r_ra     <= A;
      r_ar     <= B;
      r_acc    <= '0;
      r_pronto <= 1'b0;
    end else if (SAIDA) begin
      r_p      <= r_acc;
      r_pronto <= 1'b1;
    end else if (w_iterate) begin
      r_acc <= acc_add(r_acc, r_ra);
      r_ar  <= r_ar - 1'b1;
    end
  end

  assign AR     = r_ar;
  assign P      = r_p;
  assign PRONTO = r_pronto;

endmodule
